// File: rtl/fd_pkg.sv
// Shared types and constants for the FAST9 fetch sequencer: FSM states,
// register-file slot codes and the radius-3 Bresenham circle offset tables.
package fd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        EVAL  = 3'd3,
        ADV   = 3'd4,
        DONE  = 3'd5
    } fd_state_e;

    localparam logic [4:0] REG_NOLOAD = 5'd31;
    localparam int         NUM_SLOTS  = 32'sd17;
    localparam int         RADIUS     = 32'sd3;

    // Slot 0 is the centre; slots 1..16 walk the circle clockwise from the top.
    function automatic int circle_dx(input logic [4:0] k);
        int d;
        case (k)
            5'd0:    d = 32'sd0;
            5'd1:    d = 32'sd0;
            5'd2:    d = 32'sd1;
            5'd3:    d = 32'sd2;
            5'd4:    d = 32'sd3;
            5'd5:    d = 32'sd3;
            5'd6:    d = 32'sd3;
            5'd7:    d = 32'sd2;
            5'd8:    d = 32'sd1;
            5'd9:    d = 32'sd0;
            5'd10:   d = -32'sd1;
            5'd11:   d = -32'sd2;
            5'd12:   d = -32'sd3;
            5'd13:   d = -32'sd3;
            5'd14:   d = -32'sd3;
            5'd15:   d = -32'sd2;
            5'd16:   d = -32'sd1;
            default: d = 32'sd0;
        endcase
        return d;
    endfunction

    function automatic int circle_dy(input logic [4:0] k);
        int d;
        case (k)
            5'd0:    d = 32'sd0;
            5'd1:    d = -32'sd3;
            5'd2:    d = -32'sd3;
            5'd3:    d = -32'sd2;
            5'd4:    d = -32'sd1;
            5'd5:    d = 32'sd0;
            5'd6:    d = 32'sd1;
            5'd7:    d = 32'sd2;
            5'd8:    d = 32'sd3;
            5'd9:    d = 32'sd3;
            5'd10:   d = 32'sd3;
            5'd11:   d = 32'sd2;
            5'd12:   d = 32'sd1;
            5'd13:   d = 32'sd0;
            5'd14:   d = -32'sd1;
            5'd15:   d = -32'sd2;
            5'd16:   d = -32'sd3;
            default: d = 32'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fd_circle_rom.sv
// Combinational slot-to-address-offset table: dy*IMG_W + dx as a
// two's-complement ADDR_W value, so base+offset wraps modulo 2^ADDR_W.
module fd_circle_rom
    import fd_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int ADDR_W = 17
) (
    input  logic [4:0]               k,
    output logic signed [ADDR_W-1:0] offset
);

    // Constant per slot; folds to a small ROM once IMG_W is fixed.
    always_comb begin
        offset = ADDR_W'(circle_dy(k) * IMG_W + circle_dx(k));
    end

endmodule

// File: rtl/fd_fetch_ctrl.sv
// FAST9 fetch sequencer: walks every non-border centre, issues 17 SRAM reads
// per centre into the pixel register file, then hands off to the detector.
module fd_fetch_ctrl
    import fd_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    input  logic              abort,
    input  logic              detAck,
    output logic [ADDR_W-1:0] sramAddr,
    output logic              sramRe,
    output logic [4:0]        regAddr,
    output logic              readen,
    output logic [15:0]       pixX,
    output logic [15:0]       pixY,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0]       X_FIRST    = 16'(RADIUS);
    localparam logic [15:0]       Y_FIRST    = 16'(RADIUS);
    localparam logic [15:0]       X_LAST     = 16'(IMG_W - RADIUS - 32'sd1);
    localparam logic [15:0]       Y_LAST     = 16'(IMG_H - RADIUS - 32'sd1);
    localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'(RADIUS * IMG_W + RADIUS);
    // Wrapping from x=IMG_W-4 to x=3 on the next row moves the base by 2*RADIUS+1.
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(32'sd2 * RADIUS + 32'sd1);
    localparam logic [ADDR_W-1:0] COL_STEP   = ADDR_W'(32'sd1);
    localparam logic [4:0]        K_LAST     = 5'(NUM_SLOTS - 32'sd1);

    fd_state_e         state_r;
    fd_state_e         state_s;
    logic [4:0]        k_r;
    logic [4:0]        k_s;
    logic [15:0]       x_r;
    logic [15:0]       x_s;
    logic [15:0]       y_r;
    logic [15:0]       y_s;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0] addr_s;
    logic              re_s;
    logic [4:0]        reg_s;
    logic              readen_s;
    logic              busy_s;
    logic              done_s;

    // The ROM is indexed by the next slot so the address leaves a register.
    fd_circle_rom #(
        .IMG_W (IMG_W),
        .ADDR_W(ADDR_W)
    ) u_circle_rom (
        .k     (k_s),
        .offset(off_s)
    );

    assign addr_s = re_s ? (base_s + off_s) : {ADDR_W{1'b0}};
    assign pixX   = x_r;
    assign pixY   = y_r;

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        x_s      = x_r;
        y_s      = y_r;
        base_s   = base_r;
        re_s     = 1'b0;
        reg_s    = REG_NOLOAD;
        readen_s = 1'b0;
        busy_s   = busy;
        done_s   = 1'b0;
        if (abort) begin
            state_s = IDLE;
            k_s     = 5'd0;
            x_s     = 16'd0;
            y_s     = 16'd0;
            base_s  = {ADDR_W{1'b0}};
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = FETCH;
                        k_s     = 5'd0;
                        x_s     = X_FIRST;
                        y_s     = Y_FIRST;
                        base_s  = BASE_FIRST;
                        re_s    = 1'b1;
                        busy_s  = 1'b1;
                    end else begin
                        busy_s  = 1'b0;
                    end
                end
                FETCH: begin
                    // Read data lands one cycle later, so the slot code lags by one.
                    reg_s = k_r;
                    if (k_r == K_LAST) begin
                        state_s = DRAIN;
                    end else begin
                        k_s  = k_r + 5'd1;
                        re_s = 1'b1;
                    end
                end
                DRAIN: begin
                    state_s  = EVAL;
                    readen_s = 1'b1;
                end
                EVAL: begin
                    if (detAck) begin
                        state_s = ADV;
                    end else begin
                        readen_s = 1'b1;
                    end
                end
                ADV: begin
                    if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        if (x_r == X_LAST) begin
                            x_s    = X_FIRST;
                            y_s    = y_r + 16'd1;
                            base_s = base_r + ROW_STEP;
                        end else begin
                            x_s    = x_r + 16'd1;
                            base_s = base_r + COL_STEP;
                        end
                        state_s = FETCH;
                        k_s     = 5'd0;
                        re_s    = 1'b1;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                    k_s     = 5'd0;
                    x_s     = 16'd0;
                    y_s     = 16'd0;
                    base_s  = {ADDR_W{1'b0}};
                    busy_s  = 1'b0;
                end
                default: begin
                    state_s = IDLE;
                    k_s     = 5'd0;
                    x_s     = 16'd0;
                    y_s     = 16'd0;
                    base_s  = {ADDR_W{1'b0}};
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State, scan position and all outputs are registered together.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_r  <= IDLE;
            k_r      <= 5'd0;
            x_r      <= 16'd0;
            y_r      <= 16'd0;
            base_r   <= {ADDR_W{1'b0}};
            sramAddr <= {ADDR_W{1'b0}};
            sramRe   <= 1'b0;
            regAddr  <= REG_NOLOAD;
            readen   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            k_r      <= k_s;
            x_r      <= x_s;
            y_r      <= y_s;
            base_r   <= base_s;
            sramAddr <= addr_s;
            sramRe   <= re_s;
            regAddr  <= reg_s;
            readen   <= readen_s;
            busy     <= busy_s;
            done     <= done_s;
        end
    end

endmodule
